// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES/SNES serial pad reader.
package nes_pad_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } pad_state_t;

  // Shift lengths for the two pad families
  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  // Bit positions inside a pad's button word (first bit shifted is A)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_pad_sync.sv
// Two-flop synchroniser for the asynchronous pad data lines.
// Resets to all-1 so an idle/unplugged line reads as "not pressed".
module nes_pad_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops per line; first stage may go metastable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Self-timed NES/SNES pad reader: latches all pads, clocks NUM_BITS bits out
// of each in parallel, and publishes active-high button words with a valid
// pulse. Optional periodic polling; requests arriving mid-read coalesce into
// a single follow-up read.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = 8,
  parameter int HALF_PERIOD = 6,
  parameter int POLL_CYCLES = 420000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         auto_en,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic                         busy
);

  localparam int PW = $clog2(2*HALF_PERIOD);
  localparam int BW = $clog2(NUM_BITS);
  localparam int TW = $clog2(POLL_CYCLES);

  localparam logic [PW-1:0] PH_LATCH_LAST = PW'(2*HALF_PERIOD-1);
  localparam logic [PW-1:0] PH_HALF_LAST  = PW'(HALF_PERIOD-1);
  localparam logic [BW-1:0] BIT_LAST      = BW'(NUM_BITS-1);
  localparam logic [TW-1:0] POLL_LAST     = TW'(POLL_CYCLES-1);

  pad_state_t state, state_nxt;

  logic [PW-1:0] phase;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] poll_timer;
  logic          poll_tick;
  logic          pending;
  logic          req;
  logic          go;
  logic          sample;
  logic          last_sample;

  logic [NUM_PADS-1:0]               pad_sync;
  logic [NUM_PADS-1:0][NUM_BITS-1:0] shreg, shreg_nxt;
  logic [NUM_PADS-1:0][NUM_BITS-1:0] btn_q;

  nes_pad_sync #(.WIDTH(NUM_PADS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pad_data),
    .q       (pad_sync)
  );

  assign poll_tick   = auto_en && (poll_timer == POLL_LAST);
  assign req         = start | poll_tick;
  assign go          = req | pending;
  assign sample      = (state == LOW) && (phase == PH_HALF_LAST);
  assign last_sample = sample && (bit_cnt == BIT_LAST);

  // Free-running poll timer, parked at zero while polling is disabled
  always_ff @(posedge clk) begin
    if (!reset_n || !auto_en) poll_timer <= '0;
    else if (poll_tick)       poll_timer <= '0;
    else                      poll_timer <= poll_timer + 1'b1;
  end

  // One-deep request memory; cleared when IDLE takes the request
  always_ff @(posedge clk) begin
    if (!reset_n)            pending <= 1'b0;
    else if (state == IDLE)  pending <= 1'b0;
    else if (req)            pending <= 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; every timed phase ends on its phase-counter terminal
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (go) state_nxt = LATCH;
      LATCH: if (phase == PH_LATCH_LAST) state_nxt = LOW;
      LOW:   if (phase == PH_HALF_LAST)
               state_nxt = (bit_cnt == BIT_LAST) ? DONE : HIGH;
      HIGH:  if (phase == PH_HALF_LAST) state_nxt = LOW;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pad-facing and status outputs are registered from the next state so the
  // off-chip latch/clock lines never see decode glitches
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      pad_latch <= (state_nxt == LATCH);
      pad_clk   <= (state_nxt == HIGH);
      busy      <= (state_nxt != IDLE);
      valid     <= (state_nxt == DONE);
    end
  end

  // Phase counter restarts on every state change
  always_ff @(posedge clk) begin
    if (!reset_n)                phase <= '0;
    else if (state_nxt != state) phase <= '0;
    else if (state == LATCH || state == LOW || state == HIGH)
                                 phase <= phase + 1'b1;
    else                         phase <= '0;
  end

  // Bit index advances at the end of each pad_clk high phase
  always_ff @(posedge clk) begin
    if (!reset_n)                                    bit_cnt <= '0;
    else if (state == IDLE)                          bit_cnt <= '0;
    else if (state == HIGH && phase == PH_HALF_LAST) bit_cnt <= bit_cnt + 1'b1;
  end

  // Capture each pad's synchronised bit at index bit_cnt on the last LOW cycle
  always_comb begin
    shreg_nxt = shreg;
    if (sample) begin
      for (int p = 0; p < NUM_PADS; p++) shreg_nxt[p][bit_cnt] = pad_sync[p];
    end
  end

  // Shift register storage
  always_ff @(posedge clk) begin
    if (!reset_n) shreg <= '0;
    else          shreg <= shreg_nxt;
  end

  // Publish inverted result as DONE is entered, so buttons and valid coincide;
  // an aborted read never reaches here
  always_ff @(posedge clk) begin
    if (!reset_n)         btn_q <= '0;
    else if (last_sample) btn_q <= ~shreg_nxt;
  end

  assign buttons = btn_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: an 8-bit instance (short poll
// period) and a 16-bit instance, each driven by a behavioural pad model.
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start8, start16, auto8, auto16;
  logic [1:0]  pd8, pd16;
  logic        pl8, pc8, v8, busy8;
  logic        pl16, pc16, v16, busy16;
  logic [15:0] btn8;
  logic [31:0] btn16;

  int errors = 0;
  int checks = 0;

  // pad model state: pressed masks, optional stuck line, shift index
  logic [1:0][7:0]  pr8;
  logic [1:0][15:0] pr16;
  logic             stuck_en, stuck_val;
  int               idx8 = 0, idx16 = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];

  nes_pad_reader #(.NUM_PADS(2), .NUM_BITS(8), .HALF_PERIOD(6), .POLL_CYCLES(200)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .auto_en(auto8), .pad_data(pd8),
    .pad_latch(pl8), .pad_clk(pc8), .buttons(btn8), .valid(v8), .busy(busy8));

  nes_pad_reader #(.NUM_PADS(2), .NUM_BITS(16), .HALF_PERIOD(6), .POLL_CYCLES(420000)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .auto_en(auto16), .pad_data(pd16),
    .pad_latch(pl16), .pad_clk(pc16), .buttons(btn16), .valid(v16), .busy(busy16));

  // Pad shift registers: reload while latched, advance on pad_clk rise
  always @(posedge pc8 or posedge pl8)   if (pl8)  idx8  <= 0; else idx8  <= idx8 + 1;
  always @(posedge pc16 or posedge pl16) if (pl16) idx16 <= 0; else idx16 <= idx16 + 1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pd8[p]  = stuck_en ? stuck_val : ((idx8  < 8)  ? ~pr8[p][idx8[2:0]]   : 1'b1);
      pd16[p] = stuck_en ? stuck_val : ((idx16 < 16) ? ~pr16[p][idx16[3:0]] : 1'b1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboards: every valid pops one expected result
  always @(negedge clk) begin : mon8
    logic [15:0] e;
    if (v8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8_unexpected_valid: got valid=1 required no pending result");
      end else begin
        e = q8.pop_front();
        chk("dut8_buttons", 32'(btn8), 32'(e));
      end
    end
  end

  always @(negedge clk) begin : mon16
    logic [31:0] e;
    if (v16) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut16_unexpected_valid: got valid=1 required no pending result");
      end else begin
        e = q16.pop_front();
        chk("dut16_buttons", btn16, e);
      end
    end
  end

  // start is high for exactly one edge (edge t); returns at negedge of cycle t+1
  task automatic pulse8();
    start8 = 1'b1; @(negedge clk); start8 = 1'b0;
  endtask

  task automatic pulse16();
    start16 = 1'b1; @(negedge clk); start16 = 1'b0;
  endtask

  // Bounded wait for valid; k = cycle index of valid, -1 on timeout
  task automatic wait_v8(input int lim, output int k);
    k = -1;
    for (int c = 1; c <= lim; c++) begin
      if (v8) begin k = c; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;   // 0 model, 1 lines stuck 1, 2 lines stuck 0
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[8];

  int latch_cnt, latch_first, latch_last, rises, run, run_min, run_max;
  int overlap, vcnt, vk, vk2, busy1, busy104, lat104, lat105, k;
  int tv[3];
  logic pc_prev;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd0, 8'h81, 8'h00, 16'h0081};
    vt[1] = '{2'd0, 8'h00, 8'h00, 16'h0000};
    vt[2] = '{2'd0, 8'hA5, 8'h5A, 16'h5AA5};
    vt[3] = '{2'd0, 8'h01, 8'h80, 16'h8001};
    vt[4] = '{2'd1, 8'hFF, 8'hFF, 16'h0000};
    vt[5] = '{2'd2, 8'h00, 8'h00, 16'hFFFF};
    vt[6] = '{2'd0, 8'h7E, 8'hC3, 16'hC37E};
    vt[7] = '{2'd0, 8'hFF, 8'hFF, 16'hFFFF};

    reset_n = 1'b0; start8 = 1'b0; start16 = 1'b0; auto8 = 1'b0; auto16 = 1'b0;
    pr8 = '0; pr16 = '0; stuck_en = 1'b0; stuck_val = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_latch8", 32'(pl8), 32'd0);
    chk("rst_clk8",   32'(pc8), 32'd0);
    chk("rst_busy8",  32'(busy8), 32'd0);
    chk("rst_valid8", 32'(v8), 32'd0);
    chk("rst_btn8",   32'(btn8), 32'd0);
    chk("rst_btn16",  btn16, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // waveform and latency at defaults: pad0 A+RIGHT, pad1 idle
    pr8[0] = (8'd1 << BTN_A) | (8'd1 << BTN_RIGHT);
    pr8[1] = 8'h00;
    q8.push_back(16'h0081);
    latch_cnt = 0; latch_first = 0; latch_last = 0; rises = 0; run = 0;
    run_min = 999; run_max = 0; overlap = 0; vcnt = 0; vk = 0; pc_prev = 1'b0;
    pulse8();
    for (int c = 1; c <= 115; c++) begin
      if (pl8) begin latch_cnt++; if (latch_first == 0) latch_first = c; latch_last = c; end
      if (pl8 && pc8) overlap++;
      if (pc8 && !pc_prev) rises++;
      if (pc8) run++;
      if (!pc8 && pc_prev) begin
        if (run < run_min) run_min = run;
        if (run > run_max) run_max = run;
        run = 0;
      end
      if (v8) begin vcnt++; vk = c; end
      if (c == 1) busy1 = 32'(busy8);
      if (c == 104) busy104 = 32'(busy8);
      pc_prev = pc8;
      @(negedge clk);
    end
    chk("latch_first",  32'(latch_first), 32'd1);
    chk("latch_cycles", 32'(latch_cnt), 32'd12);
    chk("latch_last",   32'(latch_last), 32'd12);
    chk("clk_rises",    32'(rises), 32'd7);
    chk("clk_high_min", 32'(run_min), 32'd6);
    chk("clk_high_max", 32'(run_max), 32'd6);
    chk("clk_in_latch", 32'(overlap), 32'd0);
    chk("valid_count",  32'(vcnt), 32'd1);
    chk("valid_cycle",  32'(vk), 32'd103);
    chk("busy_t1",      32'(busy1), 32'd1);
    chk("busy_t104",    32'(busy104), 32'd0);
    chk("btn_hold",     32'(btn8), 32'h0081);

    // table of pad patterns, including stuck lines
    for (int i = 0; i < 8; i++) begin
      stuck_en  = (vt[i].mode != 2'd0);
      stuck_val = (vt[i].mode == 2'd1);
      pr8[0] = vt[i].p0;
      pr8[1] = vt[i].p1;
      q8.push_back(vt[i].exp);
      pulse8();
      wait_v8(200, k);
      chk($sformatf("vec%0d_latency", i), 32'(k), 32'd103);
      repeat (3) @(negedge clk);
    end
    stuck_en = 1'b0;

    // SNES width: pad0 bits 0 and 15, pad1 all pressed
    pr16[0] = 16'h8001;
    pr16[1] = 16'hFFFF;
    q16.push_back(32'hFFFF_8001);
    rises = 0; vk = 0; pc_prev = 1'b0;
    pulse16();
    for (int c = 1; c <= 210; c++) begin
      if (pc16 && !pc_prev) rises++;
      if (v16) vk = c;
      pc_prev = pc16;
      @(negedge clk);
    end
    chk("snes_clk_rises", 32'(rises), 32'd15);
    chk("snes_valid_cycle", 32'(vk), 32'd199);

    // automatic polling every 200 cycles
    pr8[0] = 8'h81; pr8[1] = 8'h3C;
    repeat (3) q8.push_back(16'h3C81);
    vcnt = 0;
    auto8 = 1'b1;
    for (int c = 1; c <= 1000 && vcnt < 3; c++) begin
      if (v8) begin tv[vcnt] = c; vcnt++; end
      if (vcnt == 3) auto8 = 1'b0;
      @(negedge clk);
    end
    auto8 = 1'b0;
    chk("poll_count", 32'(vcnt), 32'd3);
    chk("poll_period_a", 32'(tv[1] - tv[0]), 32'd200);
    chk("poll_period_b", 32'(tv[2] - tv[1]), 32'd200);
    repeat (250) @(negedge clk);

    // three extra starts during one read coalesce into one follow-up read
    pr8[0] = 8'h12; pr8[1] = 8'h34;
    q8.push_back(16'h3412);
    vcnt = 0; vk = 0; vk2 = 0;
    pulse8();
    for (int c = 1; c <= 320; c++) begin
      if (v8) begin vcnt++; if (vk == 0) vk = c; else vk2 = c; end
      if (c == 104) begin busy104 = 32'(busy8); lat104 = 32'(pl8); end
      if (c == 105) lat105 = 32'(pl8);
      if (c == 20 || c == 40 || c == 60) start8 = 1'b1;
      if (c == 21 || c == 41 || c == 61) start8 = 1'b0;
      if (c == 104) begin
        pr8[0] = 8'h56; pr8[1] = 8'h78;
        q8.push_back(16'h7856);
      end
      @(negedge clk);
    end
    chk("coal_valids", 32'(vcnt), 32'd2);
    chk("coal_first",  32'(vk), 32'd103);
    chk("coal_second", 32'(vk2), 32'd207);
    chk("coal_idle_gap", 32'(busy104), 32'd0);
    chk("coal_latch104", 32'(lat104), 32'd0);
    chk("coal_latch105", 32'(lat105), 32'd1);

    // reset during the HIGH phase after bit 4 aborts without publishing
    pr8[0] = 8'h0F; pr8[1] = 8'hF0;
    pulse8();
    for (int c = 1; c <= 69; c++) begin
      if (c == 68) chk("mid_high_bit4", 32'(pc8), 32'd1);
      if (c == 69) reset_n = 1'b0;
      @(negedge clk);
    end
    chk("abort_latch", 32'(pl8), 32'd0);
    chk("abort_clk",   32'(pc8), 32'd0);
    chk("abort_busy",  32'(busy8), 32'd0);
    chk("abort_valid", 32'(v8), 32'd0);
    chk("abort_btn8",  32'(btn8), 32'd0);
    chk("abort_btn16", btn16, 32'd0);
    reset_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_btn_still0", 32'(btn8), 32'd0);
    q8.push_back(16'hF00F);
    pulse8();
    wait_v8(200, k);
    chk("post_abort_latency", 32'(k), 32'd103);
    repeat (5) @(negedge clk);

    chk("q8_drained",  32'(q8.size()), 32'd0);
    chk("q16_drained", 32'(q16.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Self-timed, parametrised reader for NES (8-bit) and SNES (16-bit) serial game pads. Up to NUM_PADS controllers share one latch line and one clock line, and each pad has its own data line. The block generates all pad timing internally and can poll automatically at a fixed period. It presents debounced-by-frame, active-high button words to the game logic (paddle control) and replaces external FSM/counter/control-word pad handling.

## Interface
- NUM_PADS, 2: number of controllers read in parallel (≥1)
- NUM_BITS, 8: bits shifted per pad; 8 = NES, 16 = SNES (≥2)
- HALF_PERIOD, 6: clk cycles per pad_clk half-period (≥3)
- POLL_CYCLES, 420000: clk cycles between automatic polls (≈60 Hz at 25.175 MHz, ≥ busy length + 2)
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  poll request, sampled every cycle
- auto_en  in  1  enable periodic polling
- pad_data  in  NUM_PADS  serial data; pressed = 0; asynchronous
- pad_latch  out  1  latch strobe to all pads
- pad_clk  out  1  shift clock to all pads
- buttons  out  NUM_PADS*NUM_BITS  pressed = 1; pad p at [p*NUM_BITS +: NUM_BITS]; bit 0 = first bit shifted (A)
- valid  out  1  one-cycle pulse when buttons updates
- busy  out  1  transaction in progress

## Operation
- Reset values: pad_latch=0, pad_clk=0, buttons=0, valid=0, busy=0. Poll timer, phase counter, bit counter, shift registers, and pending flag are all 0. State is IDLE.
- pad_data passes through a 2-FF synchroniser before use.
- Request = start | poll_tick.
  - In IDLE, a request starts a transaction.
  - While busy, a request sets pending. There is at most one pending request; further requests coalesce.
  - A pending request starts a transaction on the cycle after DONE.
- Poll timer:
  - Counts while auto_en=1 and is held at 0 while auto_en=0.
  - poll_tick = (timer == POLL_CYCLES-1), after which the timer wraps to 0.
- States:
  - IDLE: outputs low. Leaves on request.
  - LATCH: pad_latch=1 for 2*HALF_PERIOD cycles, then goes to LOW.
  - LOW: pad_clk=0 for HALF_PERIOD cycles. On the last cycle, each pad's synchronised bit is shifted into its register at index bit_cnt. After the last cycle:
    - if bit_cnt == NUM_BITS-1, go to DONE;
    - otherwise go to HIGH.
  - HIGH: pad_clk=1 for HALF_PERIOD cycles, then bit_cnt+1 and back to LOW. No pad_clk pulse follows the final bit.
  - DONE: buttons <= inverted shift registers, valid=1 for one cycle, then IDLE.
- busy=1 in LATCH, LOW, HIGH and DONE.
- Phase counter width is $clog2(2*HALF_PERIOD). Bit counter width is $clog2(NUM_BITS). Poll timer width is $clog2(POLL_CYCLES). All counters wrap only at their stated terminal value.
- buttons holds its value between transactions and changes only in DONE.
- reset_n low at any point, including mid-transaction, forces reset values on the next edge. buttons clears and no partial result is published.
- A disconnected pad (data pulled high) reads as all 0.

## Timing
- Define edge t as the edge where a request is accepted in IDLE.
  - busy and pad_latch rise after t. pad_latch is high for cycles t+1 … t+2H (H = HALF_PERIOD).
  - Transaction length is 2H + (2*NUM_BITS-1)*H cycles.
  - DONE/valid occurs at cycle t+1 + that length. For defaults this is 102 cycles, so valid is at t+103.
- Per transaction: pad_clk has NUM_BITS-1 rising edges, each high for H cycles.
- Bit sampling occurs H-1 cycles after the LOW phase starts, which leaves ≥2 cycles of synchroniser settling.
- A pending request restarts latch at DONE+2, so there is at least one IDLE cycle between transactions.

## Structure
- Shared package nes_pad_pkg contains:
  - state enum (IDLE, LATCH, LOW, HIGH, DONE);
  - NES_BITS=8 and SNES_BITS=16;
  - button indices BTN_A=0, BTN_B=1, BTN_SELECT=2, BTN_START=3, BTN_UP=4, BTN_DOWN=5, BTN_LEFT=6, BTN_RIGHT=7.
- Sub-module nes_pad_sync: NUM_PADS-wide 2-FF synchroniser. Its reset value is all-1 (released).

## Test plan
- Defaults, pad0 model presses A and RIGHT, pad1 idle; pulse start at t → buttons[7:0]=8'h81, buttons[15:8]=8'h00, single valid at t+103, busy low at t+104.
- Waveform check at defaults → pad_latch high exactly 12 cycles, exactly 7 pad_clk rising edges each high 6 cycles, no pad_clk activity while pad_latch high.
- NUM_BITS=16, pad1 all pressed, pad0 bits 0 and 15 pressed → buttons=32'hFFFF_8001, 15 pad_clk pulses per transaction.
- auto_en=1, POLL_CYCLES=200 → valid every 200 cycles. Three extra start pulses during one busy window → exactly one additional transaction immediately after it.
- reset_n low for one cycle mid-HIGH phase (bit 4) → next edge pad_latch=pad_clk=busy=valid=0 and buttons=0. A following start yields a full, correct 103-cycle transaction.
- pad_data stuck 1 → buttons all 0. pad_data stuck 0 → buttons all 1.
